// File: rtl/triangle_generator.sv
// triangle_generator: free-running triangle LFO ramping between +PEAK and -PEAK with power-of-two step.
// Optional macro TRI_ZERO_STOP_EN: on stop, keep ramping until the next zero crossing (click-free stop).
module triangle_generator #(
    parameter logic signed [31:0] PEAK      = 32'sd16777216,
    parameter logic        [31:0] BASE_STEP = 32'd1024
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_start,
    input  logic [2:0]         i_freq,
    output logic signed [31:0] o_tri
);
`ifdef TRI_ZERO_STOP_EN
    typedef enum logic [1:0] {IDLE, UP, DOWN, STOPPING} state_t;
`else
    typedef enum logic [1:0] {IDLE, UP, DOWN} state_t;
`endif
    localparam logic signed [32:0] PK  = {PEAK[31], PEAK};
    localparam logic signed [32:0] NPK = -PK;

    state_t             state_q, state_d;
    logic signed [31:0] tri_q, tri_d, ramp_tri;
    logic        [31:0] step_q, step_d, new_step, ramp_step;
    logic               dir_q, dir_d, ramp_dir, hit_pos, hit_neg;
    logic signed [32:0] up_nx, dn_nx;
`ifdef TRI_ZERO_STOP_EN
    logic               zero_hit;
`endif

    // 33-bit sums so the clamp decision never sees a wrapped value
    always_comb begin
        new_step  = BASE_STEP << i_freq;
        up_nx     = $signed({tri_q[31], tri_q}) + $signed({1'b0, step_q});
        dn_nx     = $signed({tri_q[31], tri_q}) - $signed({1'b0, step_q});
        hit_pos   = up_nx >= PK;
        hit_neg   = dn_nx <= NPK;
        ramp_tri  = dir_q ? (hit_pos ? PEAK : up_nx[31:0]) : (hit_neg ? -PEAK : dn_nx[31:0]);
        ramp_dir  = dir_q ? !hit_pos : hit_neg;
        ramp_step = (ramp_dir != dir_q) ? new_step : step_q;
`ifdef TRI_ZERO_STOP_EN
        zero_hit  = dir_q ? (tri_q <= 32'sd0 && ramp_tri >= 32'sd0)
                          : (tri_q >= 32'sd0 && ramp_tri <= 32'sd0);
`endif
        state_d   = state_q;
        tri_d     = ramp_tri;
        step_d    = ramp_step;
        dir_d     = ramp_dir;
        if (state_q == IDLE) begin
            state_d = i_start ? UP : IDLE;
            tri_d   = i_start ? $signed(new_step) : 32'sd0;
            step_d  = i_start ? new_step : step_q;
            dir_d   = 1'b1;
        end else if (!i_start) begin
`ifdef TRI_ZERO_STOP_EN
            state_d = zero_hit ? IDLE : STOPPING;
            tri_d   = zero_hit ? 32'sd0 : ramp_tri;
            dir_d   = zero_hit ? 1'b1 : ramp_dir;
`else
            state_d = IDLE;
            tri_d   = 32'sd0;
            step_d  = step_q;
            dir_d   = 1'b1;
`endif
        end else begin
            state_d = ramp_dir ? UP : DOWN;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            tri_q   <= 32'sd0;
            step_q  <= BASE_STEP;
            dir_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            tri_q   <= tri_d;
            step_q  <= step_d;
            dir_q   <= dir_d;
        end
    end

    assign o_tri = tri_q;
endmodule

// File: tb/tb_triangle_generator.sv
// tb_triangle_generator: directed stimulus with expected samples queued per clock edge and checked by a monitor.
module tb_triangle_generator;
    localparam logic signed [31:0] PK = 32'sd16777216;

    typedef struct {
        int                 at;
        int                 k;
        logic signed [31:0] v;
    } exp_t;

    logic               i_clk = 1'b0;
    logic               i_rst_n = 1'b0;
    logic               i_start = 1'b0;
    logic [2:0]         i_freq = 3'd3;
    logic signed [31:0] o_tri;

    exp_t q[$];
    exp_t e;
    int   cyc = 0, base = 0, n_cmp = 0, n_bad = 0, viol = 0;

    always #5 i_clk = ~i_clk;

    triangle_generator dut (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .i_start(i_start),
        .i_freq (i_freq),
        .o_tri  (o_tri)
    );

    always @(posedge i_clk) cyc <= cyc + 1;

    always @(negedge i_clk) begin
        if (o_tri > PK || o_tri < -PK) viol = viol + 1;
        while (q.size() > 0 && q[0].at <= cyc) begin
            e = q.pop_front();
            n_cmp++;
            if (e.at != cyc || o_tri !== e.v) begin
                n_bad++;
                $display("FAIL edge_%0d: o_tri=%0d expected %0d (cycle %0d want %0d)", e.k, o_tri, e.v, cyc, e.at);
            end
        end
    end

    task automatic expect_at(input int k, input logic signed [31:0] v);
        q.push_back('{base + k, k, v});
    endtask

    task automatic wait_to(input int k);
        while (cyc < base + k) @(negedge i_clk);
    endtask

    task automatic go(input logic [2:0] f);
        @(negedge i_clk);
        base    = cyc;
        i_freq  = f;
        i_start = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge i_clk);
        i_rst_n = 1'b0;
        i_start = 1'b0;
        @(negedge i_clk);
        i_rst_n = 1'b1;
    endtask

    initial begin
        // idle after reset
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
        base = cyc;
        for (int k = 1; k <= 10; k++) expect_at(k, 32'sd0);
        wait_to(10);

        // freq 3: full waveform and long run
        go(3'd3);
        expect_at(1, 32'sd8192);
        expect_at(2047, 32'sd16769024);
        expect_at(2048, PK);
        expect_at(4096, 32'sd0);
        expect_at(6144, -PK);
        expect_at(10240, PK);
        expect_at(20000, 32'sd3932160);
        wait_to(20000);
        i_start = 1'b0;
`ifdef TRI_ZERO_STOP_EN
        expect_at(20479, 32'sd8192);
        expect_at(20480, 32'sd0);
`else
        expect_at(20001, 32'sd0);
`endif
        expect_at(20490, 32'sd0);
        wait_to(20490);

        // restart from idle, stop mid-descent
        go(3'd3);
        expect_at(1, 32'sd8192);
        expect_at(3000, 32'sd8978432);
        wait_to(3000);
        i_start = 1'b0;
`ifdef TRI_ZERO_STOP_EN
        expect_at(3001, 32'sd8970240);
        expect_at(4095, 32'sd8192);
        expect_at(4096, 32'sd0);
        expect_at(4100, 32'sd0);
        wait_to(4100);
`else
        expect_at(3001, 32'sd0);
        expect_at(3005, 32'sd0);
        wait_to(3005);
`endif

        // mid-ramp frequency change applies at the next peak
        do_reset();
        go(3'd3);
        wait_to(1000);
        i_freq = 3'd5;
        expect_at(1001, 32'sd8200192);
        expect_at(2048, PK);
        expect_at(2049, 32'sd16744448);
        expect_at(3071, -32'sd16744448);
        expect_at(3072, -PK);
        wait_to(3072);

        // freq 7 and asynchronous reset mid-ramp
        do_reset();
        go(3'd7);
        expect_at(1, 32'sd131072);
        expect_at(128, PK);
        expect_at(384, -PK);
        expect_at(640, PK);
        wait_to(700);
        #2 i_rst_n = 1'b0;
        #1;
        n_cmp++;
        if (o_tri !== 32'sd0) begin
            n_bad++;
            $display("FAIL async_reset: o_tri=%0d expected 0", o_tri);
        end
        @(negedge i_clk);
        i_rst_n = 1'b1;
        base = cyc;
        expect_at(1, 32'sd131072);
        expect_at(2, 32'sd262144);
        wait_to(2);

        // freq 0: slowest ramp
        do_reset();
        go(3'd0);
        expect_at(1, 32'sd1024);
        expect_at(16383, 32'sd16776192);
        expect_at(16384, PK);
        expect_at(16385, 32'sd16776192);
        wait_to(16386);

        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: pending=%0d expected 0", q.size());
        end
        n_cmp++;
        if (viol != 0) begin
            n_bad++;
            $display("FAIL amplitude_bound: violations=%0d expected 0", viol);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
